// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide unit holding the architectural HI/LO
// registers. It does shift-add multiplication and restoring division on operand
// magnitudes, one bit per cycle, and applies the MIPS sign rules in a final cycle.
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_Start,
    input  logic [1:0]            i_Op,
    input  logic [DATA_WIDTH-1:0] i_SrcA,
    input  logic [DATA_WIDTH-1:0] i_SrcB,
    input  logic                  i_WriteHi,
    input  logic                  i_WriteLo,
    input  logic [DATA_WIDTH-1:0] i_WriteData,
    output logic [DATA_WIDTH-1:0] o_HI,
    output logic [DATA_WIDTH-1:0] o_LO,
    output logic                  o_Busy,
    output logic                  o_Done
);

    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                  r_State;
    state_t                  w_NextState;
    logic [CW-1:0]           r_Count;
    logic                    r_IsDiv;
    logic                    r_SignA;
    logic                    r_SignB;
    logic [DATA_WIDTH-1:0]   r_A;
    logic [DATA_WIDTH-1:0]   r_B;
    logic [DATA_WIDTH-1:0]   r_RawA;
    logic [2*DATA_WIDTH-1:0] r_Acc;
    logic [DATA_WIDTH-1:0]   r_Rem;
    logic [DATA_WIDTH-1:0]   r_Quot;
    logic [DATA_WIDTH-1:0]   r_HI;
    logic [DATA_WIDTH-1:0]   r_LO;

    logic                    w_Signed;
    logic [DATA_WIDTH-1:0]   w_OpA;
    logic [DATA_WIDTH-1:0]   w_OpB;
    logic [DATA_WIDTH:0]     w_MulSum;
    logic [DATA_WIDTH:0]     w_DivShift;
    logic [DATA_WIDTH:0]     w_DivDiff;
    logic                    w_DivGe;
    logic [2*DATA_WIDTH-1:0] w_ProdNeg;
    logic [DATA_WIDTH-1:0]   w_ResHi;
    logic [DATA_WIDTH-1:0]   w_ResLo;

    // Operand preparation: signed ops iterate on magnitudes (0x80..0 maps to itself).
    assign w_Signed = ~i_Op[0];
    assign w_OpA    = (w_Signed && i_SrcA[DATA_WIDTH-1]) ? ('0 - i_SrcA) : i_SrcA;
    assign w_OpB    = (w_Signed && i_SrcB[DATA_WIDTH-1]) ? ('0 - i_SrcB) : i_SrcB;

    // One shift-add step: add the multiplicand when the current multiplier bit is set.
    assign w_MulSum = {1'b0, r_Acc[2*DATA_WIDTH-1:DATA_WIDTH]}
                    + (r_Acc[0] ? {1'b0, r_A} : '0);

    // One restoring-division step: the remainder is always below the divisor, so
    // the top bit of the trial difference is a clean borrow flag.
    assign w_DivShift = {r_Rem, r_Quot[DATA_WIDTH-1]};
    assign w_DivDiff  = w_DivShift - {1'b0, r_B};
    assign w_DivGe    = ~w_DivDiff[DATA_WIDTH];

    assign w_ProdNeg = '0 - r_Acc;

    // State register.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_NextState;
        end
    end

    // Next-state logic: start is only honoured in IDLE, RUN lasts DATA_WIDTH cycles.
    always_comb begin
        w_NextState = r_State;
        case (r_State)
            S_IDLE:  if (i_Start) w_NextState = S_RUN;
            S_RUN:   if (r_Count == '0) w_NextState = S_FIN;
            S_FIN:   w_NextState = S_IDLE;
            default: w_NextState = S_IDLE;
        endcase
    end

    // Sign fix and divide-by-zero result, evaluated from the finished datapath.
    always_comb begin
        w_ResHi = r_Acc[2*DATA_WIDTH-1:DATA_WIDTH];
        w_ResLo = r_Acc[DATA_WIDTH-1:0];
        if (!r_IsDiv) begin
            if (r_SignA ^ r_SignB) begin
                w_ResHi = w_ProdNeg[2*DATA_WIDTH-1:DATA_WIDTH];
                w_ResLo = w_ProdNeg[DATA_WIDTH-1:0];
            end
        end else if (r_B == '0) begin
            w_ResHi = r_RawA;
            w_ResLo = '1;
        end else begin
            w_ResLo = (r_SignA ^ r_SignB) ? ('0 - r_Quot) : r_Quot;
            w_ResHi = r_SignA ? ('0 - r_Rem) : r_Rem;
        end
    end

    // Datapath: launch capture, per-cycle iteration, result writeback and MTHI/MTLO.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            r_Count <= '0;
            r_IsDiv <= 1'b0;
            r_SignA <= 1'b0;
            r_SignB <= 1'b0;
            r_A     <= '0;
            r_B     <= '0;
            r_RawA  <= '0;
            r_Acc   <= '0;
            r_Rem   <= '0;
            r_Quot  <= '0;
            r_HI    <= '0;
            r_LO    <= '0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (i_Start) begin
                        r_IsDiv <= i_Op[1];
                        r_SignA <= w_Signed & i_SrcA[DATA_WIDTH-1];
                        r_SignB <= w_Signed & i_SrcB[DATA_WIDTH-1];
                        r_A     <= w_OpA;
                        r_B     <= w_OpB;
                        r_RawA  <= i_SrcA;
                        r_Acc   <= {{DATA_WIDTH{1'b0}}, w_OpB};
                        r_Rem   <= '0;
                        r_Quot  <= w_OpA;
                        r_Count <= CW'(DATA_WIDTH - 1);
                    end else begin
                        if (i_WriteHi) r_HI <= i_WriteData;
                        if (i_WriteLo) r_LO <= i_WriteData;
                    end
                end
                S_RUN: begin
                    if (r_IsDiv) begin
                        r_Rem  <= w_DivGe ? w_DivDiff[DATA_WIDTH-1:0]
                                          : w_DivShift[DATA_WIDTH-1:0];
                        r_Quot <= {r_Quot[DATA_WIDTH-2:0], w_DivGe};
                    end else begin
                        r_Acc <= {w_MulSum, r_Acc[DATA_WIDTH-1:1]};
                    end
                    if (r_Count != '0) r_Count <= r_Count - 1'b1;
                end
                S_FIN: begin
                    r_HI <= w_ResHi;
                    r_LO <= w_ResLo;
                end
                default: ;
            endcase
        end
    end

    assign o_HI   = r_HI;
    assign o_LO   = r_LO;
    assign o_Busy = (r_State != S_IDLE);
    assign o_Done = (r_State == S_FIN);

endmodule
